robotron_mem_ctrl: RTL and testbench
====================================

Name: robotron_mem_ctrl

Overview:
Bus initiator for the board's external memory bus (shared SRAM plus nibble-packed program flash). It converts single-byte CPU/blitter requests into timed bus cycles on MemAdr/MemDB/MemOE/MemWR/RamCS/RamLB/RamUB/FlashCS. Each cycle has programmable setup, strobe and hold phases. On flash reads it unpacks the {4'b0,hi,4'b0,lo} word format back into a byte. It sits between the CPU address decode and the memory pins or the memory model.

Parameters:
SETUP_CYC, 1, cycles with address and chip select valid before the strobe (minimum 1)
RD_WAIT, 2, cycles MemOE is held low on reads (minimum 1)
WR_WAIT, 2, cycles MemWR is held low on writes (minimum 1)

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high reset
req  in  1  single-cycle request strobe; honoured only while busy=0
we  in  1  1=write, 0=read; sampled with req
sel_flash  in  1  1=flash space, 0=RAM space; sampled with req
addr  in  24  byte address; sampled with req
wdata  in  8  write byte; sampled with req
busy  out  1  high from the edge after acceptance until the ack cycle
ack  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse coincident with ack on a rejected access
rdata  out  8  read byte; valid while ack=1 and held until the next ack
MemAdr  out  23  word address
MemDB_out  out  16  write data driven to the memory
MemDB_in  in  16  read data returned by the memory
MemOE  out  1  active-low output enable
MemWR  out  1  active-low write strobe
RamCS  out  1  active-low RAM select
RamLB  out  1  active-low RAM lower-byte lane
RamUB  out  1  active-low RAM upper-byte lane
FlashCS  out  1  active-low flash select

Behaviour:
- Reset (asynchronous): state=IDLE, counters=0, busy=ack=err=0, rdata=0, MemAdr=0, MemDB_out=0. MemOE, MemWR, RamCS, RamLB, RamUB and FlashCS all =1. Reset mid-cycle aborts the access immediately; no ack is issued.
- States: IDLE, SETUP, STROBE, HOLD. All outputs are registered.
- IDLE, req=1: latch we/sel_flash/addr/wdata and go to SETUP; busy=1 from the next cycle.
- IDLE, req=1, sel_flash=1, we=1 (flash is read-only): no bus activity. Next cycle ack=1, err=1, busy=0. State stays IDLE.
- Address mapping:
  - RAM: MemAdr=addr[23:1]; addr[0]=0 selects the lower lane (RamLB=0, RamUB=1); addr[0]=1 selects the upper lane (RamUB=0, RamLB=1).
  - Flash: one byte per word, MemAdr=addr[22:0]; addr[23] is ignored.
- SETUP (SETUP_CYC cycles): MemAdr valid; RamCS=0 or FlashCS=0; lane strobe asserted (RAM only); MemOE=0 already on reads. Writes: MemDB_out={wdata,wdata}.
- STROBE:
  - Reads: MemOE=0 for RD_WAIT cycles. rdata is captured on the rising edge that ends the last STROBE cycle.
    - RAM: rdata=addr[0] ? MemDB_in[15:8] : MemDB_in[7:0].
    - Flash: rdata={MemDB_in[11:8],MemDB_in[3:0]}.
  - Writes: MemWR=0 for WR_WAIT cycles.
- HOLD (1 cycle): MemOE=MemWR=1. Address, chip select, lane and MemDB_out are unchanged (hold time). Then all select and lane signals return to 1 and state goes to IDLE.
- Ack cycle: ack=1 in the first IDLE cycle after HOLD, with busy=0. A req in this cycle is accepted, giving back-to-back cycles.
- Latency from the req edge to ack=1: SETUP_CYC+WAIT+1 cycles (4 with defaults).
- req while busy=1: ignored, not queued.
- Never asserted together: RamCS and FlashCS both 0; MemOE and MemWR both 0.
- The strobe counter is sized for the larger of RD_WAIT and WR_WAIT; no wrap occurs for legal parameters.

Test Plan:
- Reset held while driving a mid-cycle write, then released -> all strobes=1 immediately, no ack; next req accepted normally.
- RAM write addr=0x00_0105, wdata=0xA5 -> MemAdr=0x000082, RamCS=0, RamUB=0, RamLB=1, MemDB_out=0xA5A5, MemWR low exactly 2 cycles; ack 4 cycles after req, err=0.
- RAM read addr=0x00_0104 with memory returning 0x3C5A -> RamLB=0, MemOE low 2 cycles, rdata=0x5A at ack; repeat with addr=0x00_0105 -> rdata=0x3C.
- Flash read addr=0x00_1234 with memory returning 0x0C07 -> FlashCS=0, MemAdr=0x001234, RamCS=1, rdata=0xC7.
- Flash write request -> no strobe toggles; ack=err=1 the next cycle.
- Back-to-back: req pulsed in the ack cycle -> new SETUP on the next edge. req pulsed while busy -> dropped, single ack only. Rebuild with RD_WAIT=5 -> read latency 7 cycles.

Source files
------------

// File: rtl/robotron_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : robotron_mem_ctrl_if
// Purpose  : Request/response and memory-pin bundle for robotron_mem_ctrl.
//            The master side is the requester plus the memory device. It
//            drives the request fields and the read data bus. The slave
//            side is the controller.
// Revision : 1.0 - initial release
// ============================================================================
interface robotron_mem_ctrl_if;
  // Requester side
  logic        req;
  logic        we;
  logic        sel_flash;
  logic [23:0] addr;
  logic [7:0]  wdata;
  logic        busy;
  logic        ack;
  logic        err;
  logic [7:0]  rdata;
  // Memory pin side
  logic [22:0] MemAdr;
  logic [15:0] MemDB_out;
  logic [15:0] MemDB_in;
  logic        MemOE;
  logic        MemWR;
  logic        RamCS;
  logic        RamLB;
  logic        RamUB;
  logic        FlashCS;

  modport master (
    output req, we, sel_flash, addr, wdata, MemDB_in,
    input  busy, ack, err, rdata,
    input  MemAdr, MemDB_out, MemOE, MemWR, RamCS, RamLB, RamUB, FlashCS
  );

  modport slave (
    input  req, we, sel_flash, addr, wdata, MemDB_in,
    output busy, ack, err, rdata,
    output MemAdr, MemDB_out, MemOE, MemWR, RamCS, RamLB, RamUB, FlashCS
  );
endinterface
`default_nettype wire

// File: rtl/robotron_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : robotron_mem_ctrl
// Purpose  : Single-byte bus initiator for shared SRAM and nibble-packed
//            program flash. Each access runs through three timed phases:
//            setup, strobe and hold. All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module robotron_mem_ctrl #(
  parameter int SETUP_CYC = 1,
  parameter int RD_WAIT   = 2,
  parameter int WR_WAIT   = 2
) (
  input  logic                clk,
  input  logic                reset,
  robotron_mem_ctrl_if.slave  bus
);

  // One down-counter serves both the setup and the strobe phase, so it is
  // sized for the longest of the three programmable phase lengths.
  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int MAX_CNT  = (SETUP_CYC > MAX_WAIT) ? SETUP_CYC : MAX_WAIT;
  localparam int CNT_W    = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LOAD    = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD    = CNT_W'(WR_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic             flash_q, flash_d;
  logic             lsb_q, lsb_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [22:0]      mem_adr_q, mem_adr_d;
  logic [15:0]      mem_db_q, mem_db_d;
  logic             mem_oe_q, mem_oe_d;
  logic             mem_wr_q, mem_wr_d;
  logic             ram_cs_q, ram_cs_d;
  logic             ram_lb_q, ram_lb_d;
  logic             ram_ub_q, ram_ub_d;
  logic             flash_cs_q, flash_cs_d;

  // State register and all registered outputs; reset aborts any access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      flash_q    <= 1'b0;
      lsb_q      <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      mem_adr_q  <= '0;
      mem_db_q   <= '0;
      mem_oe_q   <= 1'b1;
      mem_wr_q   <= 1'b1;
      ram_cs_q   <= 1'b1;
      ram_lb_q   <= 1'b1;
      ram_ub_q   <= 1'b1;
      flash_cs_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      flash_q    <= flash_d;
      lsb_q      <= lsb_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      mem_adr_q  <= mem_adr_d;
      mem_db_q   <= mem_db_d;
      mem_oe_q   <= mem_oe_d;
      mem_wr_q   <= mem_wr_d;
      ram_cs_q   <= ram_cs_d;
      ram_lb_q   <= ram_lb_d;
      ram_ub_q   <= ram_ub_d;
      flash_cs_q <= flash_cs_d;
    end
  end

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // so that every pin comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    flash_d    = flash_q;
    lsb_d      = lsb_q;
    busy_d     = busy_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    mem_adr_d  = mem_adr_q;
    mem_db_d   = mem_db_q;
    mem_oe_d   = mem_oe_q;
    mem_wr_d   = mem_wr_q;
    ram_cs_d   = ram_cs_q;
    ram_lb_d   = ram_lb_q;
    ram_ub_d   = ram_ub_q;
    flash_cs_d = flash_cs_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          if (bus.sel_flash && bus.we) begin
            // Flash is read-only: refuse without touching the bus.
            ack_d = 1'b1;
            err_d = 1'b1;
          end else begin
            we_d    = bus.we;
            flash_d = bus.sel_flash;
            lsb_d   = bus.addr[0];
            busy_d  = 1'b1;
            cnt_d   = SETUP_LOAD;
            state_d = S_SETUP;
            // Reads enable the output driver from the start of setup.
            mem_oe_d = bus.we;
            if (bus.we) begin
              mem_db_d = {bus.wdata, bus.wdata};
            end
            if (bus.sel_flash) begin
              // One byte per flash word; the top address bit is ignored.
              mem_adr_d  = bus.addr[22:0];
              flash_cs_d = 1'b0;
            end else begin
              mem_adr_d = bus.addr[23:1];
              ram_cs_d  = 1'b0;
              ram_lb_d  = bus.addr[0];
              ram_ub_d  = ~bus.addr[0];
            end
          end
        end
      end

      S_SETUP: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = S_STROBE;
          cnt_d   = we_q ? WR_LOAD : RD_LOAD;
          if (we_q) begin
            mem_wr_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_STROBE: begin
        if (cnt_q == CNT_ZERO) begin
          state_d  = S_HOLD;
          mem_oe_d = 1'b1;
          mem_wr_d = 1'b1;
          if (!we_q) begin
            // Flash words carry the byte as {4'b0,hi,4'b0,lo}.
            if (flash_q) begin
              rdata_d = {bus.MemDB_in[11:8], bus.MemDB_in[3:0]};
            end else if (lsb_q) begin
              rdata_d = bus.MemDB_in[15:8];
            end else begin
              rdata_d = bus.MemDB_in[7:0];
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_HOLD: begin
        // Address, selects and data were held through this cycle.
        state_d    = S_IDLE;
        busy_d     = 1'b0;
        ack_d      = 1'b1;
        ram_cs_d   = 1'b1;
        ram_lb_d   = 1'b1;
        ram_ub_d   = 1'b1;
        flash_cs_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.MemAdr    = mem_adr_q;
  assign bus.MemDB_out = mem_db_q;
  assign bus.MemOE     = mem_oe_q;
  assign bus.MemWR     = mem_wr_q;
  assign bus.RamCS     = ram_cs_q;
  assign bus.RamLB     = ram_lb_q;
  assign bus.RamUB     = ram_ub_q;
  assign bus.FlashCS   = flash_cs_q;

endmodule
`default_nettype wire

// File: tb/tb_robotron_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_robotron_mem_ctrl
// Purpose  : Self-checking bench for robotron_mem_ctrl using directed cases
//            and randomized accesses against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_robotron_mem_ctrl;
  localparam int SETUP_CYC = 1;
  localparam int RD_WAIT   = 2;
  localparam int WR_WAIT   = 2;
  localparam int RD_WAIT_B = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  robotron_mem_ctrl_if bus();
  robotron_mem_ctrl_if bus_b();

  robotron_mem_ctrl #(.SETUP_CYC(SETUP_CYC), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  robotron_mem_ctrl #(.SETUP_CYC(SETUP_CYC), .RD_WAIT(RD_WAIT_B), .WR_WAIT(WR_WAIT)) u_dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  // The memory only drives its data while selected with the output enabled.
  logic [15:0] mem_word   = 16'h0000;
  logic [15:0] mem_word_b = 16'h0000;
  assign bus.MemDB_in   = (!bus.MemOE && (!bus.RamCS || !bus.FlashCS)) ? mem_word : 16'hDEAD;
  assign bus_b.MemDB_in = (!bus_b.MemOE && (!bus_b.RamCS || !bus_b.FlashCS)) ? mem_word_b : 16'hDEAD;

  int n_checks = 0;
  int n_errors = 0;
  int last_rd  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor sampled on the falling edge.
  int          ack_cnt, busy_cyc, oe_low, wr_low, sel_cyc, clash;
  logic [22:0] seen_adr;
  logic        seen_ram, seen_fl, seen_lb, seen_ub;
  logic [15:0] seen_db;

  always @(negedge clk) begin
    if (bus.ack)  ack_cnt++;
    if (bus.busy) busy_cyc++;
    if (!bus.MemOE) oe_low++;
    if (!bus.MemWR) begin
      wr_low++;
      seen_db = bus.MemDB_out;
    end
    if (!bus.MemOE && !bus.MemWR) clash++;
    if (!bus.RamCS && !bus.FlashCS) clash++;
    if (!bus.RamCS || !bus.FlashCS) begin
      sel_cyc++;
      seen_adr = bus.MemAdr;
      seen_ram = bus.RamCS;
      seen_fl  = bus.FlashCS;
      seen_lb  = bus.RamLB;
      seen_ub  = bus.RamUB;
    end
  end

  function automatic logic [5:0] strobes();
    return {bus.MemOE, bus.MemWR, bus.RamCS, bus.FlashCS, bus.RamLB, bus.RamUB};
  endfunction

  task automatic clear_mon();
    ack_cnt = 0; busy_cyc = 0; oe_low = 0; wr_low = 0; sel_cyc = 0; clash = 0;
    seen_adr = '0; seen_ram = 1'b1; seen_fl = 1'b1; seen_lb = 1'b1; seen_ub = 1'b1;
    seen_db = '0;
  endtask

  // Present one request; returns just after the edge that samples it.
  task automatic drive_req(input logic w, input logic f, input logic [23:0] a,
                           input logic [7:0] d, input logic [15:0] m);
    bus.we = w; bus.sel_flash = f; bus.addr = a; bus.wdata = d;
    mem_word = m;
    clear_mon();
    bus.req = 1'b1;
    @(posedge clk);
    #1 bus.req = 1'b0;
  endtask

  // Edges from the request edge to the edge that raised ack.
  task automatic wait_ack(output int lat);
    bit got;
    lat = 0;
    got = 0;
    while (!got && lat <= 40) begin
      @(negedge clk);
      if (bus.ack) got = 1;
      else lat++;
    end
    #1;
    if (!got) check("ack_timeout", 32'd0, 32'd1);
  endtask

  // Full access against the reference model.
  task automatic txn(input logic w, input logic f, input logic [23:0] a,
                     input logic [7:0] d, input logic [15:0] m);
    int lat, wt;
    bit rej;
    rej = w && f;
    drive_req(w, f, a, d, m);
    wait_ack(lat);
    if (rej) begin
      check("rej_lat", lat, 0);
      check("rej_err", bus.err, 1);
      check("rej_busy", busy_cyc, 0);
      check("rej_sel", sel_cyc + oe_low + wr_low, 0);
    end else begin
      wt = w ? WR_WAIT : RD_WAIT;
      check("lat", lat, SETUP_CYC + wt + 1);
      check("err", bus.err, 0);
      check("busy_cyc", busy_cyc, lat);
      check("sel_cyc", sel_cyc, lat);
      check("adr", seen_adr, f ? (a % (1 << 23)) : (a / 2));
      check("ramcs", seen_ram, f ? 1 : 0);
      check("flashcs", seen_fl, f ? 0 : 1);
      check("lb", seen_lb, (f || (a % 2 == 1)) ? 1 : 0);
      check("ub", seen_ub, (f || (a % 2 == 0)) ? 1 : 0);
      check("oe_low", oe_low, w ? 0 : SETUP_CYC + RD_WAIT);
      check("wr_low", wr_low, w ? WR_WAIT : 0);
      if (w) check("db_out", seen_db, d * 257);
    end
    check("clash", clash, 0);
    check("ack_cnt", ack_cnt, 1);
    if (!w) begin
      if (f) last_rd = (((m / 256) % 16) * 16) + (m % 16);
      else   last_rd = (a % 2 == 1) ? (m / 256) : (m % 256);
    end
    check("rdata", bus.rdata, last_rd);
    check("busy_at_ack", bus.busy, 0);
    check("strobes_at_ack", strobes(), 6'h3F);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, oe_b;
    logic [23:0] ra;
    logic [15:0] rm;
    bit got;

    bus.req = 0; bus.we = 0; bus.sel_flash = 0; bus.addr = '0; bus.wdata = '0;
    bus_b.req = 0; bus_b.we = 0; bus_b.sel_flash = 0; bus_b.addr = '0; bus_b.wdata = '0;
    clear_mon();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_err", bus.err, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_adr", bus.MemAdr, 0);
    check("rst_db", bus.MemDB_out, 0);
    check("rst_strobes", strobes(), 6'h3F);
    #1 reset = 1'b0;

    // Reset in the middle of a write aborts it with no ack
    drive_req(1'b1, 1'b0, 24'h000105, 8'hA5, 16'h0000);
    @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("abort_strobes", strobes(), 6'h3F);
    check("abort_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("abort_no_ack", ack_cnt, 0);
    last_rd = 0;

    // Directed cases
    txn(1'b1, 1'b0, 24'h000105, 8'hA5, 16'h0000);
    txn(1'b0, 1'b0, 24'h000104, 8'h00, 16'h3C5A);
    txn(1'b0, 1'b0, 24'h000105, 8'h00, 16'h3C5A);
    txn(1'b0, 1'b1, 24'h001234, 8'h00, 16'h0C07);
    txn(1'b1, 1'b1, 24'h001234, 8'h77, 16'h0000);
    txn(1'b0, 1'b1, 24'h801234, 8'h00, 16'h0F03);

    // Request while busy is dropped, only one ack results
    drive_req(1'b0, 1'b0, 24'h000200, 8'h00, 16'h1234);
    @(negedge clk);
    #1 bus.we = 1'b1; bus.addr = 24'h000301; bus.wdata = 8'hEE; bus.req = 1'b1;
    @(posedge clk);
    #1 bus.req = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("drop_ack_cnt", ack_cnt, 1);
    check("drop_wr_low", wr_low, 0);
    check("drop_adr", seen_adr, 24'h000200 / 2);
    last_rd = 8'h34;
    check("drop_rdata", bus.rdata, last_rd);

    // Randomized accesses, sometimes issued in the ack cycle
    for (int i = 0; i < 40; i++) begin
      txn(1'($urandom), 1'($urandom), 24'($urandom), 8'($urandom), 16'($urandom));
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(negedge clk);
        #1;
      end
    end

    // Longer read strobe on the second instance
    for (int i = 0; i < 3; i++) begin
      ra = 24'($urandom);
      rm = 16'($urandom);
      @(negedge clk);
      #1;
      mem_word_b = rm;
      bus_b.we = 1'b0; bus_b.sel_flash = 1'b0; bus_b.addr = ra; bus_b.req = 1'b1;
      @(posedge clk);
      #1 bus_b.req = 1'b0;
      lat = 0; got = 0; oe_b = 0;
      while (!got && lat <= 40) begin
        @(negedge clk);
        if (bus_b.ack) got = 1;
        else begin
          lat++;
          if (!bus_b.MemOE) oe_b++;
        end
      end
      #1;
      check("b_got_ack", got, 1);
      check("b_lat", lat, SETUP_CYC + RD_WAIT_B + 1);
      check("b_oe_low", oe_b, SETUP_CYC + RD_WAIT_B);
      check("b_rdata", bus_b.rdata, (ra % 2 == 1) ? (rm / 256) : (rm % 256));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
